// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, default data width and issue-FSM state encoding
// for the alu_issue command-issue / result-capture stage.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int OP_W          = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b011;
  localparam logic [OP_W-1:0] OP_DIV  = 3'b100;
  localparam logic [OP_W-1:0] OP_MOD  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_state_e;

  // Divide and modulo are the only ops that can fault on a zero divisor.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding packed {op, a, b} commands.
// Push is ignored when full and pop is ignored when empty, so callers may
// drive raw requests. DEPTH must be a power of two so pointers wrap freely.
module alu_cmd_fifo #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once pointers reset, so no reset here.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: buffers ALU commands in a FIFO, issues them one at a time to a
// combinational ALU, and registers each result into a valid/ready response.
// Optional macro ALU_DIV_ZERO_CHK_EN: when defined, div/mod by zero returns
// all-ones with rsp_err_o set instead of the ALU result.
//
// state | meaning
// IDLE  | nothing issued; pop FIFO head into ALU drive regs when available
// EXEC  | ALU settling on issued command; capture result next edge
// RESP  | response held until accepted; then issue next or go idle
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_op_i,
  input  logic [WIDTH-1:0]           cmd_a_i,
  input  logic [WIDTH-1:0]           cmd_b_i,
  output logic [2:0]                 alu_ctrl_o,
  output logic [WIDTH-1:0]           alu_data0_o,
  output logic [WIDTH-1:0]           alu_data1_o,
  input  logic [WIDTH-1:0]           alu_result_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic [2:0]                 rsp_op_o,
  output logic                       rsp_err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = OP_W + 2 * WIDTH;

  alu_state_e         state_q, state_d;
  logic [OP_W-1:0]    alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]   alu_data0_q, alu_data0_d;
  logic [WIDTH-1:0]   alu_data1_q, alu_data1_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [OP_W-1:0]    rsp_op_q, rsp_op_d;
  logic               rsp_err_q, rsp_err_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENT_W-1:0]   fifo_wdata;
  logic [ENT_W-1:0]   fifo_rdata;
  logic [OP_W-1:0]    head_op;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               div_zero;

  assign fifo_wdata               = {cmd_op_i, cmd_a_i, cmd_b_i};
  assign {head_op, head_a, head_b} = fifo_rdata;

  // Ready is purely from registered occupancy, so a pop in the same cycle
  // never opens a slot for a push on a full FIFO.
  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;

  alu_cmd_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

`ifdef ALU_DIV_ZERO_CHK_EN
  assign div_zero = is_div_op(alu_ctrl_q) && (alu_data1_q == '0);
`else
  assign div_zero = 1'b0;
`endif

  // Issue FSM: next state, FIFO pop, ALU drive and response register updates.
  always_comb begin
    state_d     = state_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_data0_d = alu_data0_q;
    alu_data1_d = alu_data1_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          alu_ctrl_d  = head_op;
          alu_data0_d = head_a;
          alu_data1_d = head_b;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_op_d    = alu_ctrl_q;
        rsp_err_d   = div_zero;
        rsp_data_d  = div_zero ? '1 : alu_result_i;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            alu_ctrl_d  = head_op;
            alu_data0_d = head_a;
            alu_data1_d = head_b;
            state_d     = ST_EXEC;
          end else begin
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, ALU drive and response registers; reset drops anything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      alu_ctrl_q  <= '0;
      alu_data0_q <= '0;
      alu_data1_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_data0_q <= alu_data0_d;
      alu_data1_q <= alu_data1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_ctrl_o  = alu_ctrl_q;
  assign alu_data0_o = alu_data0_q;
  assign alu_data1_o = alu_data1_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_op_o    = rsp_op_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
